// File: rtl/layer4_pkg.sv
// Shared constants, state encoding and address helpers for the layer-4 frame buffer.
package layer4_pkg;

   localparam int L4_AW = 8;
   localparam int L4_DW = 128;
   localparam logic [L4_AW-1:0] L4_DEPTH = 8'd144;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } l4_state_e;

   // A read may only target a word that already exists in the current frame.
   function automatic logic rd_addr_ok(input logic [L4_AW-1:0] addr,
                                       input logic [L4_AW-1:0] ptr);
      return (addr < ptr) && (addr < L4_DEPTH);
   endfunction

   function automatic logic addr_out_of_range(input logic [L4_AW-1:0] addr);
      return (addr >= L4_DEPTH);
   endfunction

endpackage

// File: rtl/layer4_wrapper.sv
// Dual-port SRAM model: port A and port B each write on WExN=0 and register a read on OEx=1.
module layer4_wrapper
   import layer4_pkg::*;
(
   input  logic             CK,
   input  logic [L4_AW-1:0] A,
   input  logic             WEAN,
   input  logic             OEA,
   input  logic [L4_DW-1:0] DIA,
   output logic [L4_DW-1:0] DOA,
   input  logic [L4_AW-1:0] B,
   input  logic             WEBN,
   input  logic             OEB,
   input  logic [L4_DW-1:0] DIB,
   output logic [L4_DW-1:0] DOB
);

   logic [L4_DW-1:0] mem [0:L4_DEPTH-1];
   logic [L4_DW-1:0] doa_r;
   logic [L4_DW-1:0] dob_r;

   // Array write ports; both ports may write in the same cycle.
   always_ff @(posedge CK) begin
      if (!WEAN) begin
         mem[A] <= DIA;
      end
      if (!WEBN) begin
         mem[B] <= DIB;
      end
   end

   // Registered read data, one cycle after the output enable.
   always_ff @(posedge CK) begin
      if (OEA) begin
         doa_r <= mem[A];
      end
      if (OEB) begin
         dob_r <= mem[B];
      end
   end

   assign DOA = doa_r;
   assign DOB = dob_r;

endmodule

// File: rtl/layer4_buffer_ctrl.sv
// Layer-4 frame buffer controller: sequential writes on SRAM port A, random-access reads on port B.
module layer4_buffer_ctrl
   import layer4_pkg::*;
(
   input  logic             CK,
   input  logic             RSTN,
   input  logic             start,
   input  logic             wr_req,
   input  logic [L4_DW-1:0] wr_data,
   output logic             wr_gnt,
   input  logic             rd_req,
   input  logic [L4_AW-1:0] rd_addr,
   output logic             rd_gnt,
   output logic             rd_valid,
   output logic [L4_DW-1:0] rd_data,
   output logic [L4_AW-1:0] fill_cnt,
   output logic             frame_done,
   output logic             err
);

   l4_state_e        state_r;
   l4_state_e        state_n;
   logic [L4_AW-1:0] wr_ptr_r;
   logic [L4_AW-1:0] wr_ptr_n;
   logic [L4_AW-1:0] wr_ptr_inc_s;
   logic             wr_gnt_s;
   logic             wr_err_s;
   logic             rd_gnt_s;
   logic             rd_err_s;
   logic             rd_valid_r;
   logic             frame_done_r;
   logic             frame_done_n;
   logic             err_r;
   logic             err_n;

   logic             wean_s;
   logic             webn_s;
   logic             oea_s;
   logic             oeb_s;
   logic [L4_AW-1:0] a_s;
   logic [L4_AW-1:0] b_s;
   logic [L4_DW-1:0] dia_s;
   logic [L4_DW-1:0] dib_s;
   logic [L4_DW-1:0] doa_s;
   logic [L4_DW-1:0] dob_s;

   assign wr_ptr_inc_s = wr_ptr_r + 8'd1;

   // Write-side FSM: grant, pointer advance, frame completion; start wins over any write.
   always_comb begin
      state_n      = state_r;
      wr_ptr_n     = wr_ptr_r;
      frame_done_n = 1'b0;
      wr_gnt_s     = 1'b0;
      wr_err_s     = 1'b0;
      case (state_r)
         IDLE:    wr_err_s = wr_req & ~start;
         FILL:    wr_gnt_s = wr_req & ~start;
         FULL:    wr_err_s = wr_req & ~start;
         default: state_n  = IDLE;
      endcase
      if (start) begin
         state_n  = FILL;
         wr_ptr_n = 8'd0;
      end else if (wr_gnt_s) begin
         wr_ptr_n = wr_ptr_inc_s;
         if (wr_ptr_inc_s == L4_DEPTH) begin
            state_n      = FULL;
            frame_done_n = 1'b1;
         end else begin
            frame_done_n = 1'b0;
         end
      end else begin
         wr_ptr_n = wr_ptr_r;
      end
   end

   // Read grant: only words already written in this frame; out-of-range addresses are errors.
   always_comb begin
      rd_gnt_s = 1'b0;
      rd_err_s = 1'b0;
      if (rd_req) begin
         rd_gnt_s = (state_r != IDLE) && rd_addr_ok(rd_addr, wr_ptr_r);
         rd_err_s = addr_out_of_range(rd_addr);
      end else begin
         rd_gnt_s = 1'b0;
         rd_err_s = 1'b0;
      end
      err_n = wr_err_s | rd_err_s;
   end

   // Control state and registered status pulses.
   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         state_r      <= IDLE;
         wr_ptr_r     <= 8'd0;
         rd_valid_r   <= 1'b0;
         frame_done_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_n;
         wr_ptr_r     <= wr_ptr_n;
         rd_valid_r   <= rd_gnt_s;
         frame_done_r <= frame_done_n;
         err_r        <= err_n;
      end
   end

   // SRAM strobes come straight from the grants, so a write or read lands on the granting edge.
   assign wean_s = ~wr_gnt_s;
   assign a_s    = wr_ptr_r;
   assign dia_s  = wr_data;
   assign oea_s  = 1'b0;
   assign webn_s = 1'b1;
   assign dib_s  = {L4_DW{1'b0}};
   assign oeb_s  = rd_gnt_s;
   assign b_s    = rd_addr;

   layer4_wrapper u_sram (
      .CK   (CK),
      .A    (a_s),
      .WEAN (wean_s),
      .OEA  (oea_s),
      .DIA  (dia_s),
      .DOA  (doa_s),
      .B    (b_s),
      .WEBN (webn_s),
      .OEB  (oeb_s),
      .DIB  (dib_s),
      .DOB  (dob_s)
   );

   assign wr_gnt     = wr_gnt_s;
   assign rd_gnt     = rd_gnt_s;
   assign rd_valid   = rd_valid_r;
   // Port A is never read, so its output only fills the don't-care slots of rd_data.
   assign rd_data    = rd_valid_r ? dob_s : doa_s;
   assign fill_cnt   = wr_ptr_r;
   assign frame_done = frame_done_r;
   assign err        = err_r;

endmodule
